// File: rtl/seg_scan_reader_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_reader_pkg : shared segment constants and default sizing
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg_scan_reader_pkg;

  localparam int DEFAULT_DIGITS  = 8;
  localparam int DEFAULT_CLK_DIV = 50000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first so HEX7_TABLE[v] decodes v
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/seg_scan_reader_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg : combinational 4-bit hex to active-low 7-segment decoder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex7seg
  import seg_scan_reader_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX7_TABLE[nibble];
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_reader.sv
// ---------------------------------------------------------------------------
// seg_scan_reader : double-buffered multiplexed 7-segment scanner.
// Optional leading-zero blanking is built when SEG_BLANK_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_scan_reader
  import seg_scan_reader_pkg::*;
#(
  parameter int DIGITS  = DEFAULT_DIGITS,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_tick_q, frame_tick_d;

  logic              tick;
  logic              wrap;
  logic [3:0]        cur_nibble;
  logic [6:0]        dec_seg;
  logic [6:0]        lit_seg;

  always_comb begin
    tick       = (cnt_q == CNT_LAST);
    wrap       = tick && (idx_q == IDX_LAST);
    cur_nibble = disp_data_q[{idx_q, 2'b00} +: 4];
  end

  hex7seg u_hex7seg (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef SEG_BLANK_EN
  // zero_above[k]: digit k and every more-significant digit are zero
  logic [DIGITS-1:0] zero_above;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_zero_above
      if (k == 0) begin : g_digit0
        assign zero_above[k] = 1'b0;
      end else begin : g_upper
        assign zero_above[k] = (disp_data_q[DATA_W-1:4*k] == '0);
      end
    end
  endgenerate

  always_comb begin
    lit_seg = zero_above[idx_q] ? SEG_BLANK : dec_seg;
  end
`else
  always_comb begin
    lit_seg = dec_seg;
  end
`endif

  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Commit takes the pre-edge shadow; a same-cycle load then refills it and keeps pending set
    if (wrap && pending_q) begin
      disp_data_d = shadow_data_q;
      disp_dp_d   = shadow_dp_q;
      pending_d   = 1'b0;
    end

    if (load) begin
      shadow_data_d = data_in;
      shadow_dp_d   = dp_in;
      pending_d     = 1'b1;
    end

    an_d         = ~(DIGITS'(1) << idx_q);
    seg_d        = lit_seg;
    dp_d         = ~disp_dp_q[idx_q];
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_reader.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_reader : self-checking bench for seg_scan_reader (DIGITS=8, CLK_DIV=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_reader;

  localparam int D     = 8;
  localparam int CD    = 4;
  localparam int FRAME = D * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic        pending;

  always #5 clk = ~clk;

  seg_scan_reader #(.DIGITS(D), .CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release plus the two buffers
  int          n;
  logic [31:0] m_disp, m_shadow;
  logic [7:0]  m_disp_dp, m_shadow_dp;
  logic        m_pend;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp, m_ft;

  logic [6:0]  fr_seg [8];
  logic        fr_dp  [8];

  typedef struct {
    logic [3:0] nib;
    logic [6:0] exp_seg;
  } hex_vec_t;
  hex_vec_t vecs [16];

  function automatic logic [6:0] ref_seg(input logic [31:0] v, input int k);
    logic [3:0] nib;
    nib = v[4*k +: 4];
`ifdef SEG_BLANK_EN
    if (k > 0 && (v >> (4*k)) == 32'd0) return 7'h7F;
`endif
    return hex_ref[nib];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] p);
    int   idx;
    logic wrap;
    load = ld; data_in = d; dp_in = p;
    idx  = (n / CD) % D;
    wrap = (n % FRAME) == FRAME - 1;
    m_an  = ~(8'd1 << idx);
    m_seg = ref_seg(m_disp, idx);
    m_dp  = ~m_disp_dp[idx];
    m_ft  = wrap;
    if (wrap && m_pend) begin
      m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pend = 1'b0;
    end
    if (ld) begin
      m_shadow = d; m_shadow_dp = p; m_pend = 1'b1;
    end
    @(posedge clk); #1;
    load = 1'b0;
    n++;
    chk("an", an, m_an);
    chk("seg", seg, m_seg);
    chk("dp", dp, m_dp);
    chk("frame_tick", frame_tick, m_ft);
    chk("pending", pending, m_pend);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 32'd0, 8'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_frame_tick", frame_tick, 1'b0);
    chk("rst_pending", pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0; m_pend = 1'b0;
  endtask

  task automatic wait_commit();
    int guard = 0;
    while (pending && guard < 3 * FRAME) begin
      idle(1);
      guard++;
    end
    chk("commit_timeout", pending, 1'b0);
  endtask

  task automatic scan_frame();
    for (int k = 0; k < D; k++) begin fr_seg[k] = 'x; fr_dp[k] = 1'bx; end
    for (int i = 0; i < FRAME; i++) begin
      idle(1);
      for (int k = 0; k < D; k++)
        if (an == ~(8'd1 << k)) begin fr_seg[k] = seg; fr_dp[k] = dp; end
    end
  endtask

  task automatic advance_to_phase(input int ph);
    int guard = 0;
    while ((n % FRAME) != ph && guard < FRAME) begin
      idle(1);
      guard++;
    end
  endtask

  int ft_cnt;
  logic [31:0] rv;

  initial begin
    for (int v = 0; v < 16; v++) begin
      vecs[v].nib     = 4'(v);
      vecs[v].exp_seg = hex_ref[v];
    end

    do_reset();

    // Idle scan: anodes walk, all zeros decode, frame_tick every FRAME cycles
    ft_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle(1);
      if (frame_tick) ft_cnt++;
    end
    chk("idle_ft_count", ft_cnt, 2);

    // Mid-frame load: held back until the frame boundary
    advance_to_phase(10);
    step(1'b1, 32'h0123ABCD, 8'h01);
    chk("pend_after_load", pending, 1'b1);
    idle(5);
    chk("disp_unchanged", seg, 7'h40);
    wait_commit();
    scan_frame();
    chk("d0_seg_0123ABCD", fr_seg[0], 7'h21);
    chk("d0_dp_lit", fr_dp[0], 1'b0);
    chk("d1_dp_dark", fr_dp[1], 1'b1);
`ifdef SEG_BLANK_EN
    chk("d7_seg_0123ABCD", fr_seg[7], 7'h7F);
`else
    chk("d7_seg_0123ABCD", fr_seg[7], 7'h40);
`endif

    // Two loads in one frame: the last wins
    advance_to_phase(3);
    step(1'b1, 32'h11111111, 8'h00);
    idle(4);
    step(1'b1, 32'h22222222, 8'h00);
    wait_commit();
    scan_frame();
    chk("last_load_wins", fr_seg[3], 7'h24);

    // Load coincident with wrap: old shadow commits, new one stays pending
    advance_to_phase(5);
    step(1'b1, 32'h55555555, 8'h00);
    advance_to_phase(FRAME - 1);
    step(1'b1, 32'hFFFFFFFF, 8'h00);
    chk("pend_after_wrap_load", pending, 1'b1);
    scan_frame();
    chk("wrap_frame_5", fr_seg[0], 7'h12);
    chk("pend_cleared_next_wrap", pending, 1'b0);
    scan_frame();
    chk("wrap_frame_F", fr_seg[6], 7'h0E);

    // Reset mid-frame with pending data discards the shadow
    advance_to_phase(12);
    step(1'b1, 32'hAAAAAAAA, 8'hFF);
    idle(3);
    do_reset();
    idle(FRAME + 4);
    chk("pend_after_rst", pending, 1'b0);
    scan_frame();
    chk("seg_after_rst", fr_seg[0], 7'h40);
    chk("dp_after_rst", fr_dp[0], 1'b1);

    // Leading-zero blanking patterns
    step(1'b1, 32'h00000A05, 8'h00);
    wait_commit();
    scan_frame();
    chk("blank_d0", fr_seg[0], 7'h12);
    chk("blank_d1", fr_seg[1], 7'h40);
    chk("blank_d2", fr_seg[2], 7'h08);
`ifdef SEG_BLANK_EN
    chk("blank_d3", fr_seg[3], 7'h7F);
    chk("blank_d7", fr_seg[7], 7'h7F);
`else
    chk("blank_d3", fr_seg[3], 7'h40);
    chk("blank_d7", fr_seg[7], 7'h40);
`endif

    // Table: every hex value on all digits
    for (int v = 0; v < 16; v++) begin
      step(1'b1, {8{vecs[v].nib}}, 8'h00);
      wait_commit();
      scan_frame();
      chk($sformatf("hex%0h_d0", vecs[v].nib), fr_seg[0], vecs[v].exp_seg);
`ifdef SEG_BLANK_EN
      chk($sformatf("hex%0h_d7", vecs[v].nib), fr_seg[7], (v == 0) ? 7'h7F : vecs[v].exp_seg);
`else
      chk($sformatf("hex%0h_d7", vecs[v].nib), fr_seg[7], vecs[v].exp_seg);
`endif
    end

    // Random loads against the reference model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        rv = $urandom >> $urandom_range(0, 31);
        step(1'b1, rv, 8'($urandom));
      end else begin
        idle(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
